// File: rtl/dmem_pkg.sv
// Shared types and constants for the S-Machine data memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    StResetWait,
    StClear,
    StReady
  } dmem_state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 3;

  function automatic int unsigned num_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Read response pipeline: RD_LAT stages of valid/data/err; data and err only
// advance alongside a valid bit so the output holds its last response.
module dmem_rd_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] err_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        dat_q[0] <= in_data;
        err_q[0] <= in_err;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
          err_q[i] <= err_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_data  = dat_q[RD_LAT-1];
  assign out_err   = err_q[RD_LAT-1];

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory for the S-Machine CPU: valid/ready requests, byte-lane writes, RD_LAT read pipe.
// Define DMEM_INIT_CLEAR_EN to zero-fill the array after every reset.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 2**ADDR_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [num_lanes(DATA_W)-1:0] req_be,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         init_done
);

  localparam int unsigned Lanes = num_lanes(DATA_W);
  localparam bit ParamsOk = (RD_LAT >= RD_LAT_MIN) && (RD_LAT <= RD_LAT_MAX) &&
                            (DATA_W % 8 == 0) && (DEPTH <= (1 << ADDR_W));

  dmem_state_e state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic in_range, acc, wr_en, rd_en;
  logic clr_we, clr_last;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] rd_data;

  assign in_range = 32'(req_addr) < DEPTH;
  assign acc      = req_valid & req_ready;
  assign wr_en    = acc & req_we & in_range;
  assign rd_en    = acc & ~req_we;
  assign rd_data  = in_range ? mem[req_addr] : '0;

`ifdef DMEM_INIT_CLEAR_EN
  logic [ADDR_W-1:0] clr_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_ptr_q <= '0;
    end else if (clr_we) begin
      clr_ptr_q <= clr_ptr_q + 1'b1;
    end
  end

  assign clr_last = (32'(clr_ptr_q) == DEPTH - 1);
  assign clr_addr = clr_ptr_q;
`else
  assign clr_last = 1'b1;
  assign clr_addr = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StResetWait;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    init_done = 1'b0;
    clr_we    = 1'b0;
    unique case (state_q)
`ifdef DMEM_INIT_CLEAR_EN
      StResetWait: state_d = StClear;
`else
      StResetWait: state_d = StReady;
`endif
      StClear: begin
        clr_we = 1'b1;
        if (clr_last) state_d = StReady;
      end
      StReady: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_d = StResetWait;
    endcase
  end

  // The array itself carries no reset; zero-fill (if built in) is the clear sweep.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < Lanes; i++) begin
        if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  dmem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en),
    .in_data   (rd_data),
    .in_err    (~in_range),
    .out_valid (rsp_valid),
    .out_data  (rsp_rdata),
    .out_err   (rsp_err)
  );

  assert property (@(posedge clk) ParamsOk);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl (DEPTH=200, RD_LAT=2); clear-sweep checks under DMEM_INIT_CLEAR_EN.
module tb_dmem_ctrl;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 200;
  localparam int unsigned RD_LAT = 2;
`ifdef DMEM_INIT_CLEAR_EN
  localparam int WantWait = DEPTH + 1;
`else
  localparam int WantWait = 1;
`endif

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          at_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid, rsp_err, init_done;
  logic [15:0] rsp_rdata;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [15:0] model [256];

  dmem_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk_eq("rsp_data", 32'(rsp_rdata), 32'(e.data));
        chk_eq("rsp_err", 32'(rsp_err), 32'(e.err));
        chk_eq("rsp_edge", 32'(cyc), 32'(e.at_edge));
      end
    end
  end

  // Called just after a rising edge; request is accepted at the next edge.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be);
    bit in_rng;
    exp_t e;
    in_rng    = int'(addr) < DEPTH;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    if (we) begin
      if (in_rng) begin
        if (be[0]) model[addr][7:0] = wdata[7:0];
        if (be[1]) model[addr][15:8] = wdata[15:8];
      end
    end else begin
      e.data    = in_rng ? model[addr] : 16'h0000;
      e.err     = !in_rng;
      e.at_edge = cyc + 1 + int'(RD_LAT) - 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(input int want);
    int n = 0;
    while (!req_ready && n < int'(DEPTH) + 20) begin
      @(negedge clk);
      if (!req_ready) n++;
    end
    chk_eq("ready_wait_cycles", 32'(n), 32'(want));
    chk_eq("init_done", 32'(init_done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk_eq("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic model_after_reset();
`ifdef DMEM_INIT_CLEAR_EN
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_be = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_req_ready", 32'(req_ready), 32'd0);
    chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk_eq("rst_init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
    repeat (100) @(posedge clk);
    #1;
    chk_eq("clear_ready_low", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif
    wait_ready(WantWait);
    model_after_reset();
`ifdef DMEM_INIT_CLEAR_EN
    do_req(1'b0, 8'h05, 16'h0, 2'b00);
    do_req(1'b0, 8'hC7, 16'h0, 2'b00);
`endif

    // Basic write/read, then be=0 write must leave the word alone.
    do_req(1'b1, 8'h10, 16'hBEEF, 2'b11);
    do_req(1'b0, 8'h10, 16'h0, 2'b00);
    do_req(1'b1, 8'h10, 16'hFFFF, 2'b00);
    do_req(1'b0, 8'h10, 16'h0, 2'b11);

    // Byte-lane merge with read right after write.
    do_req(1'b1, 8'h20, 16'h1234, 2'b11);
    do_req(1'b1, 8'h20, 16'hAB00, 2'b10);
    do_req(1'b0, 8'h20, 16'h0, 2'b00);
    do_req(1'b1, 8'h21, 16'h00CD, 2'b01);
    do_req(1'b1, 8'h21, 16'hEF00, 2'b10);
    do_req(1'b0, 8'h21, 16'h0, 2'b00);

    // Out-of-range reads and dropped writes.
    do_req(1'b1, 8'h00, 16'h0F0F, 2'b11);
    do_req(1'b0, 8'hC8, 16'h0, 2'b00);
    do_req(1'b1, 8'hC8, 16'h5555, 2'b11);
    do_req(1'b1, 8'hFF, 16'hAAAA, 2'b11);
    do_req(1'b0, 8'h00, 16'h0, 2'b00);
    do_req(1'b0, 8'hFF, 16'h0, 2'b00);
    do_req(1'b1, 8'hC7, 16'h7E57, 2'b11);
    do_req(1'b0, 8'hC7, 16'h0, 2'b00);
    drain();

    // Back-to-back reads.
    do_req(1'b1, 8'h01, 16'h1111, 2'b11);
    do_req(1'b1, 8'h02, 16'h2222, 2'b11);
    do_req(1'b1, 8'h03, 16'h3333, 2'b11);
    do_req(1'b0, 8'h01, 16'h0, 2'b00);
    do_req(1'b0, 8'h02, 16'h0, 2'b00);
    do_req(1'b0, 8'h03, 16'h0, 2'b00);
    drain();
    chk_eq("hold_rdata", 32'(rsp_rdata), 32'h3333);

    // Reset with reads in flight: nothing may come out.
    do_req(1'b0, 8'h10, 16'h0, 2'b00);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h20;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_eq("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("flush_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk_eq("flush_rsp_err", 32'(rsp_err), 32'd0);
    chk_eq("flush_req_ready", 32'(req_ready), 32'd0);
    chk_eq("flush_init_done", 32'(init_done), 32'd0);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("flush_hold_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    wait_ready(WantWait);
    model_after_reset();
    repeat (5) @(posedge clk);
    #1;
    chk_eq("post_flush_idle", 32'(rsp_valid), 32'd0);
    do_req(1'b1, 8'h30, 16'hC0DE, 2'b11);
    do_req(1'b0, 8'h30, 16'h0, 2'b00);
    do_req(1'b0, 8'h01, 16'h0, 2'b00);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
